// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul stream engine: FSM state
// encoding, the tag that travels with each operand pair through the
// read/MAC pipeline, and the signed saturation helper.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One tag per issued A/B address pair. It is delayed to line up with the
    // returning read data. first clears the accumulator and last emits a C element.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // Working width of sat_clamp. Callers sign-extend into it and truncate back out.
    localparam int CLAMP_W = 128;

    // Clamp a signed accumulator value to the signed data_w-bit range.
    function automatic logic signed [CLAMP_W-1:0] sat_clamp(
        input logic signed [CLAMP_W-1:0] acc,
        input int                        data_w
    );
        logic signed [CLAMP_W-1:0] one;
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        one = CLAMP_W'(1);
        hi  = (one <<< (data_w - 1)) - one;
        lo  = -hi - one;
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end else begin
            return acc;
        end
    endfunction

endpackage

// File: rtl/matmul_stream_engine_if.sv
// Bundle for the job descriptor channel, the A/B SRAM read ports, the C write
// port and the completion status of the matmul stream engine.
// The slave modport is the engine side. The master modport is the host/memory side.
interface matmul_stream_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 16
);
    logic              job_valid;
    logic              job_ready;
    logic [DIM_W-1:0]  job_m;
    logic [DIM_W-1:0]  job_n;
    logic [DIM_W-1:0]  job_k;
    logic [ADDR_W-1:0] job_a_base;
    logic [ADDR_W-1:0] job_b_base;
    logic [ADDR_W-1:0] job_c_base;
    logic              job_transpose_b;
    logic [ADDR_W-1:0] a_rd_addr;
    logic [DATA_W-1:0] a_rd_data;
    logic [ADDR_W-1:0] b_rd_addr;
    logic [DATA_W-1:0] b_rd_data;
    logic              c_wr_en;
    logic [ADDR_W-1:0] c_wr_addr;
    logic [DATA_W-1:0] c_wr_data;
    logic              done;
    logic              dim_err;

    modport slave (
        input  job_valid, job_m, job_n, job_k,
        input  job_a_base, job_b_base, job_c_base, job_transpose_b,
        input  a_rd_data, b_rd_data,
        output job_ready, a_rd_addr, b_rd_addr,
        output c_wr_en, c_wr_addr, c_wr_data, done, dim_err
    );

    modport master (
        output job_valid, job_m, job_n, job_k,
        output job_a_base, job_b_base, job_c_base, job_transpose_b,
        output a_rd_data, b_rd_data,
        input  job_ready, a_rd_addr, b_rd_addr,
        input  c_wr_en, c_wr_addr, c_wr_data, done, dim_err
    );
endinterface

// File: rtl/matmul_stream_engine_mac_acc.sv
// Signed multiply-accumulate stage. It consumes one operand pair per cycle.
// A pair tagged first clears the accumulator. A pair tagged last registers
// the finished element, either saturated or truncated to DATA_W.
module mac_acc
    import matmul_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 64,
    parameter bit SATURATE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  tag_t                     tag,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic [DATA_W-1:0]          res;

    // Full-precision product, accumulate (or restart), and output narrowing.
    always_comb begin
        prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        prod_ext = ACC_W'(prod);
        acc_next = tag.first ? prod_ext : acc + prod_ext;
        res      = acc_next[DATA_W-1:0];
        if (SATURATE) begin
            res = DATA_W'(sat_clamp(CLAMP_W'(acc_next), DATA_W));
        end
    end

    // Accumulator register and the registered C element strobe/data.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= tag.valid & tag.last;
            if (tag.valid) begin
                acc <= acc_next;
            end
            if (tag.valid && tag.last) begin
                out_data <= res;
            end
        end
    end

endmodule

// File: rtl/matmul_stream_engine.sv
// Streaming signed matrix multiply, C = A x B or C = A x B^T, over
// single-port SRAMs with one-cycle read latency. It issues one MAC per cycle
// in i/j/k loop order and writes C row-major.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | job_ready high, waiting for a descriptor
//  ISSUE | one A/B read address pair per cycle
//  DRAIN | two cycles to flush the read and MAC pipeline
//  DONE  | done pulse (dim_err with it for zero-size jobs)
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 64,
    parameter int ADDR_W   = 12,
    parameter int DIM_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    matmul_stream_engine_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]        state;

    // Loop counters count down to a terminal zero and reload from the latched extent minus one.
    logic [DIM_W-1:0]  i_rem;
    logic [DIM_W-1:0]  j_rem;
    logic [DIM_W-1:0]  k_rem;
    logic [DIM_W-1:0]  j_reload;
    logic [DIM_W-1:0]  k_reload;
    logic              k_first;
    logic              drain_cnt;

    // Address walkers. The row bases step by strides, so no multipliers are needed.
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] a_row;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] b_row;
    logic [ADDR_W-1:0] b_base_q;
    logic [ADDR_W-1:0] k_stride;
    logic [ADDR_W-1:0] b_kstep;
    logic [ADDR_W-1:0] b_jstep;
    logic [ADDR_W-1:0] c_ptr;
    logic [ADDR_W-1:0] c_addr_q;

    logic              done_q;
    logic              dim_err_q;
    tag_t              tag_d1;
    logic              mac_valid;
    logic [DATA_W-1:0] mac_data;
    logic              zero_dim;

    assign zero_dim      = (bus.job_m == '0) || (bus.job_n == '0) || (bus.job_k == '0);
    assign bus.job_ready = (state == S_IDLE);
    assign bus.a_rd_addr = a_addr;
    assign bus.b_rd_addr = b_addr;
    assign bus.c_wr_en   = mac_valid;
    assign bus.c_wr_addr = c_addr_q;
    assign bus.c_wr_data = mac_data;
    assign bus.done      = done_q;
    assign bus.dim_err   = dim_err_q;

    // Sequencer: descriptor capture, i/j/k address walk, drain timer, and C address tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            i_rem     <= '0;
            j_rem     <= '0;
            k_rem     <= '0;
            j_reload  <= '0;
            k_reload  <= '0;
            k_first   <= 1'b0;
            drain_cnt <= 1'b0;
            a_addr    <= '0;
            a_row     <= '0;
            b_addr    <= '0;
            b_row     <= '0;
            b_base_q  <= '0;
            k_stride  <= '0;
            b_kstep   <= '0;
            b_jstep   <= '0;
            c_ptr     <= '0;
            c_addr_q  <= '0;
            done_q    <= 1'b0;
            dim_err_q <= 1'b0;
            tag_d1    <= '0;
        end else begin
            done_q    <= 1'b0;
            dim_err_q <= 1'b0;
            tag_d1    <= '0;

            // The C address is captured when the element's last pair reaches the MAC,
            // so it lines up with the registered write data.
            if (tag_d1.valid && tag_d1.last) begin
                c_addr_q <= c_ptr;
                c_ptr    <= c_ptr + ADDR_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        if (zero_dim) begin
                            state     <= S_DONE;
                            done_q    <= 1'b1;
                            dim_err_q <= 1'b1;
                        end else begin
                            state    <= S_ISSUE;
                            i_rem    <= bus.job_m - DIM_W'(1);
                            j_rem    <= bus.job_n - DIM_W'(1);
                            k_rem    <= bus.job_k - DIM_W'(1);
                            j_reload <= bus.job_n - DIM_W'(1);
                            k_reload <= bus.job_k - DIM_W'(1);
                            k_first  <= 1'b1;
                            a_addr   <= bus.job_a_base;
                            a_row    <= bus.job_a_base;
                            b_addr   <= bus.job_b_base;
                            b_row    <= bus.job_b_base;
                            b_base_q <= bus.job_b_base;
                            c_ptr    <= bus.job_c_base;
                            k_stride <= ADDR_W'(bus.job_k);
                            b_kstep  <= bus.job_transpose_b ? ADDR_W'(1) : ADDR_W'(bus.job_n);
                            b_jstep  <= bus.job_transpose_b ? ADDR_W'(bus.job_k) : ADDR_W'(1);
                        end
                    end
                end

                S_ISSUE: begin
                    tag_d1 <= '{valid: 1'b1, first: k_first, last: (k_rem == '0)};
                    if (k_rem != '0) begin
                        k_rem   <= k_rem - DIM_W'(1);
                        k_first <= 1'b0;
                        a_addr  <= a_addr + ADDR_W'(1);
                        b_addr  <= b_addr + b_kstep;
                    end else begin
                        k_rem   <= k_reload;
                        k_first <= 1'b1;
                        if (j_rem != '0) begin
                            j_rem  <= j_rem - DIM_W'(1);
                            a_addr <= a_row;
                            b_row  <= b_row + b_jstep;
                            b_addr <= b_row + b_jstep;
                        end else begin
                            j_rem  <= j_reload;
                            b_row  <= b_base_q;
                            b_addr <= b_base_q;
                            if (i_rem != '0) begin
                                i_rem  <= i_rem - DIM_W'(1);
                                a_row  <= a_row + k_stride;
                                a_addr <= a_row + k_stride;
                            end else begin
                                state     <= S_DRAIN;
                                drain_cnt <= 1'b1;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == 1'b0) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b0;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    mac_acc #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_mac_acc (
        .clk       (clk),
        .reset     (reset),
        .tag       (tag_d1),
        .a         ($signed(bus.a_rd_data)),
        .b         ($signed(bus.b_rd_data)),
        .out_valid (mac_valid),
        .out_data  (mac_data)
    );

endmodule
